// File: rtl/key_matrix_scanner.sv
// Keypad matrix scanner: column strobing, row sync, frame-level debounce and an event FIFO.
// Optional build macro KEY_RELEASE_EN queues release events alongside presses.
module key_matrix_scanner #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 16,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CODE_W         = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   v,
  output logic [COLS-1:0]   h,
  output logic [CODE_W-1:0] key_code,
  output logic              key_rel,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              ghost,
  output logic              overflow
);

  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
`ifdef KEY_RELEASE_EN
  localparam bit RelEn = 1'b1;
`else
  localparam bit RelEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StPressCand, StHeld, StRelCand} state_e;

  logic              started_q, started_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [ROWS-1:0]   v_meta_q, v_sync_q;
  logic [1:0]        hits_q, hits_d;
  logic [CODE_W-1:0] fcode_q, fcode_d;
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic              ghost_q, ghost_d, ovf_q, ovf_d;
  logic [PtrW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CODE_W:0]   mem_q [FIFO_DEPTH];

  logic [1:0]        col_hits, tot;
  logic [2:0]        sum;
  logic [CODE_W-1:0] col_code, frm_code, push_code;
  logic [CntW-1:0]   cnt_inc;
  logic              sample, frame_end, res_none, res_single, res_multi, same_key;
  logic              push, push_rel, fifo_valid, fifo_full, pop, wr_en;
  logic [CODE_W:0]   head;

  // Rows seen low in the column being strobed; counts saturate at 2 (enough to flag a ghost).
  always_comb begin
    col_hits = 2'd0;
    col_code = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (!v_sync_q[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = CODE_W'(int'(col_q) * int'(ROWS) + r);
      end
    end
    sum        = {1'b0, hits_q} + {1'b0, col_hits};
    tot        = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    frm_code   = (col_hits != 2'd0) ? col_code : fcode_q;
    sample     = started_q && (div_q == DivW'(SCAN_DIV - 1));
    frame_end  = sample && (col_q == ColW'(COLS - 1));
    res_none   = frame_end && (tot == 2'd0);
    res_single = frame_end && (tot == 2'd1);
    res_multi  = frame_end && (tot == 2'd2);
    same_key   = res_single && (frm_code == cand_q);
  end

  always_comb begin
    started_d = 1'b1;
    div_d     = div_q;
    col_d     = col_q;
    hits_d    = hits_q;
    fcode_d   = fcode_q;
    if (started_q) begin
      if (sample) begin
        div_d   = '0;
        col_d   = (col_q == ColW'(COLS - 1)) ? '0 : col_q + ColW'(1);
        hits_d  = frame_end ? 2'd0 : tot;
        fcode_d = frm_code;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  // Debounce: a multi-key frame is treated as "no change" and leaves the FSM untouched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    push      = 1'b0;
    push_rel  = 1'b0;
    push_code = cand_q;
    cnt_inc   = cnt_q + CntW'(1);
    if (frame_end && !res_multi) begin
      case (state_q)
        StIdle: if (res_single) begin
          cand_d = frm_code;
          cnt_d  = CntW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            push      = 1'b1;
            push_code = frm_code;
            state_d   = StHeld;
          end else begin
            state_d = StPressCand;
          end
        end
        StPressCand: begin
          if (same_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntW'(DEBOUNCE_SCANS)) begin
              push    = 1'b1;
              state_d = StHeld;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: if (!same_key) begin
          cnt_d = CntW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            push     = RelEn;
            push_rel = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StRelCand;
          end
        end
        StRelCand: begin
          if (same_key) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntW'(DEBOUNCE_SCANS)) begin
              push     = RelEn;
              push_rel = 1'b1;
              state_d  = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  always_comb begin
    fifo_valid = (wptr_q != rptr_q);
    fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    pop        = fifo_valid && key_ready;
    wr_en      = push && (!fifo_full || pop);
    ovf_d      = push && fifo_full && !pop;
    ghost_d    = res_multi;
    wptr_d     = wptr_q + {{PtrW{1'b0}}, wr_en};
    rptr_d     = rptr_q + {{PtrW{1'b0}}, pop};
    head       = mem_q[rptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started_q <= 1'b0;
      col_q     <= '0;
      div_q     <= '0;
      v_meta_q  <= '1;
      v_sync_q  <= '1;
      hits_q    <= 2'd0;
      fcode_q   <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      cand_q    <= '0;
      ghost_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      started_q <= started_d;
      col_q     <= col_d;
      div_q     <= div_d;
      v_meta_q  <= v;
      v_sync_q  <= v_meta_q;
      hits_q    <= hits_d;
      fcode_q   <= fcode_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      ghost_q   <= ghost_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[PtrW-1:0]] <= {push_rel, push_code};
  end

  assign h         = started_q ? ~(COLS'(1) << col_q) : '1;
  assign key_valid = fifo_valid;
  assign key_code  = fifo_valid ? head[CODE_W-1:0] : '0;
  assign key_rel   = RelEn && fifo_valid && head[CODE_W];
  assign ghost     = ghost_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a keypad model and an event scoreboard.
// Honours KEY_RELEASE_EN the same way the design does.
module tb_key_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int FRAME = 64;
  localparam int DEPTH = 4;
`ifdef KEY_RELEASE_EN
  localparam bit RelEn = 1'b1;
`else
  localparam bit RelEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_ready = 1'b0;
  logic [3:0] v, h, key_code;
  logic       key_rel, key_valid, ghost, overflow;
  logic [15:0] pressed = '0;

  int n_cmp = 0, n_bad = 0, ghost_cnt = 0, ovf_cnt = 0, exp_ovf = 0, g0;
  logic [4:0] exp_q[$];
  logic [3:0] fill_keys [8] = '{4'd2, 4'd4, 4'd8, 4'd11, 4'd14, 4'd1, 4'd3, 4'd9};

  key_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(16), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .v(v), .h(h), .key_code(key_code), .key_rel(key_rel),
    .key_valid(key_valid), .key_ready(key_ready), .ghost(ghost), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Passive keypad: a closed switch pulls its row low while its column is strobed.
  always_comb begin
    v = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (pressed[c*ROWS+r] && !h[c]) v[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [3:0] code, input logic rel);
    if (exp_q.size() >= DEPTH) exp_ovf++;
    else exp_q.push_back({rel, code});
  endtask

  task automatic press(input int k);
    pressed[k] = 1'b1;
    tick(3 * FRAME);
    sb_push(4'(k), 1'b0);
  endtask

  task automatic release_key(input int k);
    pressed[k] = 1'b0;
    tick(3 * FRAME);
    if (RelEn) sb_push(4'(k), 1'b1);
  endtask

  task automatic drain(input string tag);
    key_ready = 1'b1;
    tick(FRAME);
    check({tag, "_valid_low"}, 32'(key_valid), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    key_ready = 1'b0;
  endtask

  // Consumer side: every accepted event must match the scoreboard head.
  always @(negedge clk) begin
    logic [4:0] e;
    if (ghost) ghost_cnt++;
    if (overflow) ovf_cnt++;
    if (!reset && key_valid && key_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL pop_unexpected: observed code %0d rel %0d, expected no event",
               key_code, key_rel);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_code", 32'(key_code), 32'(e[3:0]));
        check("pop_rel", 32'(key_rel), 32'(e[4]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_h", 32'(h), 32'hF);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_rel", 32'(key_rel), 32'd0);
    check("rst_ghost", 32'(ghost), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick(1);
    check("h_col0", 32'(h), 32'hE);
    tick(16); check("h_col1", 32'(h), 32'hD);
    tick(16); check("h_col2", 32'(h), 32'hB);
    tick(16); check("h_col3", 32'(h), 32'h7);
    tick(16); check("h_wrap", 32'(h), 32'hE);

    // Key 6 (col1,row2): event appears the cycle after the 3rd frame ends, once only.
    pressed[6] = 1'b1;
    tick(3 * FRAME - 1);
    check("k6_not_yet", 32'(key_valid), 32'd0);
    tick(1);
    check("k6_valid", 32'(key_valid), 32'd1);
    check("k6_code", 32'(key_code), 32'd6);
    check("k6_rel", 32'(key_rel), 32'd0);
    sb_push(4'd6, 1'b0);
    tick(FRAME);
    check("k6_stable_code", 32'(key_code), 32'd6);
    release_key(6);
    drain("k6");

    // Key 15 bounces: 1 frame, gap, then held; needs 3 consecutive frames.
    pressed[15] = 1'b1; tick(FRAME);
    pressed[15] = 1'b0; tick(FRAME);
    pressed[15] = 1'b1; tick(2 * FRAME);
    check("k15_bounce_none", 32'(key_valid), 32'd0);
    tick(FRAME);
    check("k15_valid", 32'(key_valid), 32'd1);
    check("k15_code", 32'(key_code), 32'd15);
    sb_push(4'd15, 1'b0);
    release_key(15);
    drain("k15");

    // Two keys in one frame: ghost every frame, nothing queued.
    g0 = ghost_cnt;
    pressed[1] = 1'b1; pressed[9] = 1'b1;
    tick(5 * FRAME);
    pressed[1] = 1'b0; pressed[9] = 1'b0;
    tick(2);
    check("ghost_pulses", 32'(ghost_cnt - g0), 32'd5);
    check("ghost_no_event", 32'(key_valid), 32'd0);
    tick(FRAME - 2);

    // Five presses into a stalled queue: excess dropped with overflow.
    press(0); release_key(0);
    press(3); release_key(3);
    press(7); release_key(7);
    press(10); release_key(10);
    press(12); release_key(12);
    check("ovf_count", 32'(ovf_cnt), 32'(exp_ovf));
    check("full_head_code", 32'(key_code), 32'(exp_q[0][3:0]));
    drain("ovf");

    // Full queue with a pop in the push cycle: both succeed, no overflow.
    for (int i = 0; i < 8 && exp_q.size() < DEPTH; i++) begin
      press(int'(fill_keys[i]));
      release_key(int'(fill_keys[i]));
    end
    pressed[13] = 1'b1;
    tick(3 * FRAME - 1);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    sb_push(4'd13, 1'b0);
    tick(2);
    check("simul_no_ovf", 32'(ovf_cnt), 32'(exp_ovf));
    check("simul_valid", 32'(key_valid), 32'd1);
    tick(FRAME - 2);
    release_key(13);
    drain("simul");

    // Async reset mid-frame with queued events.
    for (int k = 5; k < 8 && exp_q.size() < 2; k++) begin
      press(k);
      release_key(k);
    end
    tick(20);
    check("pre_rst_valid", 32'(key_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_h", 32'(h), 32'hF);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_code", 32'(key_code), 32'd0);
    exp_q.delete();
    tick(3);
    reset = 1'b0;
    tick(1);
    check("post_rst_h", 32'(h), 32'hE);
    check("post_rst_valid", 32'(key_valid), 32'd0);
    tick(2 * FRAME);
    check("post_rst_empty", 32'(key_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
